// File: rtl/prog_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prog_seq_pkg
// Brief   : Shared types and program base-address table for prog_sequencer.
// Revision: 1.0
// ============================================================================
package prog_seq_pkg;

    localparam int A_DEF     = 10;
    localparam int NPROG_DEF = 3;
    localparam int CW_DEF    = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARMED    = 3'd1,
        ST_RUN      = 3'd2,
        ST_HALTED   = 3'd3,
        ST_FINISHED = 3'd4
    } seq_state_t;

    localparam logic [A_DEF-1:0] BASE [1:3] = '{10'd0, 10'd150, 10'd500};

    // Program numbers outside 1..3 (e.g. before the first Start) map to 0.
    function automatic logic [A_DEF-1:0] base_addr(input logic [1:0] idx);
        logic [A_DEF-1:0] addr;
        case (idx)
            2'd1:    addr = BASE[1];
            2'd2:    addr = BASE[2];
            2'd3:    addr = BASE[3];
            default: addr = '0;
        endcase
        return addr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : prog_sequencer_if
// Brief   : Test-bench/decoder/PC-facing signal bundle of prog_sequencer.
// Revision: 1.0
// ============================================================================
interface prog_sequencer_if #(
    parameter int A  = 10,
    parameter int CW = 16
);
    logic          Start;
    logic          HaltInstr;
    logic          BranchRelEn;
    logic          ALU_flag;
    logic [7:0]    Target;
    logic          PcEn;
    logic          PcLoad;
    logic [A-1:0]  PcLoadAddr;
    logic [1:0]    ProgIdx;
    logic          Done;
    logic          AllDone;
    logic [CW-1:0] CycleCnt;

    modport master (
        output Start, HaltInstr, BranchRelEn, ALU_flag, Target,
        input  PcEn, PcLoad, PcLoadAddr, ProgIdx, Done, AllDone, CycleCnt
    );

    modport slave (
        input  Start, HaltInstr, BranchRelEn, ALU_flag, Target,
        output PcEn, PcLoad, PcLoadAddr, ProgIdx, Done, AllDone, CycleCnt
    );
endinterface
`default_nettype wire

// File: rtl/prog_sequencer_edge_det.sv
`default_nettype none
// ============================================================================
// Module  : edge_det
// Brief   : Registers a level and flags its rising/falling edges.
// Revision: 1.0
// ============================================================================
module edge_det (
    input  wire logic Clk,
    input  wire logic Reset_n,
    input  wire logic In,
    output logic      Rise,
    output logic      Fall
);
    logic in_q;
    logic in_d;

    always_comb begin
        in_d = In;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in_d;
        end
    end

    assign Rise = In & ~in_q;
    assign Fall = ~In & in_q;
endmodule
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : prog_sequencer
// Brief   : Launches benchmark programs, steers PC load/enable, counts cycles.
// Revision: 1.0
// ============================================================================
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int A     = A_DEF,
    parameter int NPROG = NPROG_DEF,
    parameter int CW    = CW_DEF
) (
    input  wire logic         Clk,
    input  wire logic         Reset_n,
    prog_sequencer_if.slave   bus
);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [1:0]    LAST_IDX = 2'(NPROG);

    seq_state_t    state_q, state_d;
    logic [1:0]    prog_idx_q, prog_idx_d;
    logic          done_q, done_d;
    logic          all_done_q, all_done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          start_rise;
    logic          start_fall;
    logic [A-1:0]  base;

    edge_det u_start_edge (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .In      (bus.Start),
        .Rise    (start_rise),
        .Fall    (start_fall)
    );

    assign base = A'(base_addr(prog_idx_q));

    always_comb begin
        state_d        = state_q;
        prog_idx_d     = prog_idx_q;
        done_d         = done_q;
        all_done_d     = all_done_q;
        cnt_d          = cnt_q;
        bus.PcEn       = 1'b0;
        bus.PcLoad     = 1'b0;
        bus.PcLoadAddr = '0;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start_rise) begin
                    prog_idx_d = prog_idx_q + 2'd1;
                    done_d     = 1'b0;
                    state_d    = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (start_fall) begin
                    bus.PcLoad     = 1'b1;
                    bus.PcLoadAddr = base;
                    cnt_d          = '0;
                    state_d        = ST_RUN;
                end
            end
            ST_RUN: begin
                // Halt wins over a same-cycle branch and is not counted.
                if (bus.HaltInstr) begin
                    done_d = 1'b1;
                    if (prog_idx_q == LAST_IDX) begin
                        all_done_d = 1'b1;
                        state_d    = ST_FINISHED;
                    end else begin
                        state_d    = ST_HALTED;
                    end
                end else begin
                    bus.PcEn = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                    if (bus.BranchRelEn && bus.ALU_flag) begin
                        bus.PcLoad     = 1'b1;
                        bus.PcLoadAddr = base + A'(bus.Target);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            prog_idx_q <= 2'd0;
            done_q     <= 1'b0;
            all_done_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            prog_idx_q <= prog_idx_d;
            done_q     <= done_d;
            all_done_q <= all_done_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.ProgIdx  = prog_idx_q;
    assign bus.Done     = done_q;
    assign bus.AllDone  = all_done_q;
    assign bus.CycleCnt = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_sequencer
// Brief   : Randomised bench for prog_sequencer with an in-bench program model.
// Revision: 1.0
// ============================================================================
module tb_prog_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prog_sequencer_if #(.A(10), .CW(16)) bus ();

    prog_sequencer #(.A(10), .NPROG(3), .CW(16)) dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Program-level model: mode 0 = waiting for a launch, 1 = launched and
    // waiting for Start release, 2 = executing, 3 = series complete.
    int base_tab [4] = '{0, 0, 150, 500};
    int m_mode = 0;
    int m_prog = 0;
    int m_cnt  = 0;
    bit m_done = 0;
    bit m_all  = 0;
    bit m_prev = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_prog = 0; m_cnt = 0;
            m_done = 0; m_all = 0; m_prev = 0;
        end else begin
            if (m_mode == 0 && bus.Start && !m_prev) begin
                m_prog = m_prog + 1;
                m_done = 0;
                m_mode = 1;
            end else if (m_mode == 1 && !bus.Start && m_prev) begin
                m_cnt  = 0;
                m_mode = 2;
            end else if (m_mode == 2) begin
                if (bus.HaltInstr) begin
                    m_done = 1;
                    if (m_prog == 3) begin
                        m_all  = 1;
                        m_mode = 3;
                    end else begin
                        m_mode = 0;
                    end
                end else if (m_cnt < 65535) begin
                    m_cnt = m_cnt + 1;
                end
            end
            m_prev = bus.Start;
        end
    end

    int e_en, e_ld, e_addr;
    always @(negedge clk) begin
        if (chk_en) begin
            e_en = 0; e_ld = 0; e_addr = 0;
            if (m_mode == 1 && !bus.Start && m_prev) begin
                e_ld   = 1;
                e_addr = base_tab[m_prog];
            end
            if (m_mode == 2 && !bus.HaltInstr) begin
                e_en = 1;
                if (bus.BranchRelEn && bus.ALU_flag) begin
                    e_ld   = 1;
                    e_addr = (base_tab[m_prog] + int'(bus.Target)) % 1024;
                end
            end
            check("PcEn",       32'(bus.PcEn),       e_en);
            check("PcLoad",     32'(bus.PcLoad),     e_ld);
            check("PcLoadAddr", 32'(bus.PcLoadAddr), e_addr);
            check("ProgIdx",    32'(bus.ProgIdx),    m_prog);
            check("Done",       32'(bus.Done),       32'(m_done));
            check("AllDone",    32'(bus.AllDone),    32'(m_all));
            check("CycleCnt",   32'(bus.CycleCnt),   m_cnt);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int n_high);
        bus.Start = 1'b1;
        repeat (n_high) step();
        bus.Start = 1'b0;
    endtask

    task automatic rand_exec();
        bus.BranchRelEn = 1'($urandom_range(0, 1));
        bus.ALU_flag    = 1'($urandom_range(0, 1));
        bus.Target      = 8'($urandom_range(0, 255));
    endtask

    task automatic clear_exec();
        bus.HaltInstr   = 1'b0;
        bus.BranchRelEn = 1'b0;
        bus.ALU_flag    = 1'b0;
        bus.Target      = 8'd0;
    endtask

    initial begin
        bus.Start = 1'b0;
        clear_exec();

        // Reset, then idle with Start low.
        rst_n = 1'b0;
        repeat (2) step();
        chk_en = 1'b1;
        rst_n  = 1'b1;
        @(negedge clk);
        check("rst_ProgIdx",  32'(bus.ProgIdx),  0);
        check("rst_Done",     32'(bus.Done),     0);
        check("rst_CycleCnt", 32'(bus.CycleCnt), 0);
        repeat (10) step();

        // Program 1.
        launch(3);
        @(negedge clk);
        check("p1_ProgIdx", 32'(bus.ProgIdx),    1);
        check("p1_PcLoad",  32'(bus.PcLoad),     1);
        check("p1_LoadAdr", 32'(bus.PcLoadAddr), 0);
        step();
        @(negedge clk);
        check("p1_PcEn", 32'(bus.PcEn), 1);
        step();
        @(negedge clk);
        check("p1_Cnt1", 32'(bus.CycleCnt), 1);
        repeat (6) begin rand_exec(); step(); end
        bus.HaltInstr = 1'b1;
        step();
        clear_exec();
        @(negedge clk);
        check("p1_Done", 32'(bus.Done), 1);
        check("p1_Cnt",  32'(bus.CycleCnt), 7);

        // Program 2: branches, mid-run Start pulse, halt beating a branch.
        launch(2);
        step();
        for (int i = 0; i < 20; i++) begin
            rand_exec();
            bus.Start = (i == 5 || i == 6);
            if (i == 2) begin
                bus.BranchRelEn = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 8'd37;
                @(negedge clk);
                check("p2_br_PcLoad", 32'(bus.PcLoad),     1);
                check("p2_br_Addr",   32'(bus.PcLoadAddr), 187);
            end else if (i == 3) begin
                bus.BranchRelEn = 1'b1; bus.ALU_flag = 1'b0; bus.Target = 8'd37;
                @(negedge clk);
                check("p2_nb_PcLoad", 32'(bus.PcLoad), 0);
                check("p2_nb_PcEn",   32'(bus.PcEn),   1);
            end
            step();
        end
        bus.Start = 1'b0;
        bus.HaltInstr = 1'b1; bus.BranchRelEn = 1'b1; bus.ALU_flag = 1'b1;
        @(negedge clk);
        check("p2_halt_PcLoad", 32'(bus.PcLoad), 0);
        check("p2_halt_PcEn",   32'(bus.PcEn),   0);
        step();
        clear_exec();
        @(negedge clk);
        check("p2_Done",    32'(bus.Done),     1);
        check("p2_Cnt",     32'(bus.CycleCnt), 20);
        check("p2_ProgIdx", 32'(bus.ProgIdx),  2);
        repeat (3) step();
        @(negedge clk);
        check("p2_Cnt_held", 32'(bus.CycleCnt), 20);

        // Program 3: far branch, final halt, Start ignored afterwards.
        launch(2);
        @(negedge clk);
        check("p3_LoadAdr", 32'(bus.PcLoadAddr), 500);
        step();
        bus.BranchRelEn = 1'b1; bus.ALU_flag = 1'b1; bus.Target = 8'd255;
        @(negedge clk);
        check("p3_br_Addr", 32'(bus.PcLoadAddr), 755);
        step();
        repeat (4) begin rand_exec(); step(); end
        bus.HaltInstr = 1'b1;
        step();
        clear_exec();
        @(negedge clk);
        check("p3_Done",    32'(bus.Done),    1);
        check("p3_AllDone", 32'(bus.AllDone), 1);
        launch(2);
        repeat (2) step();
        @(negedge clk);
        check("fin_ProgIdx", 32'(bus.ProgIdx), 3);
        check("fin_AllDone", 32'(bus.AllDone), 1);
        check("fin_PcLoad",  32'(bus.PcLoad),  0);

        // Reset in the middle of program 2.
        rst_n = 1'b0; step(); rst_n = 1'b1;
        launch(2); step();
        bus.HaltInstr = 1'b1; step(); clear_exec();
        launch(2); step();
        repeat (5) begin rand_exec(); step(); end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        clear_exec();
        @(negedge clk);
        check("mr_ProgIdx",  32'(bus.ProgIdx),  0);
        check("mr_Done",     32'(bus.Done),     0);
        check("mr_CycleCnt", 32'(bus.CycleCnt), 0);
        check("mr_PcEn",     32'(bus.PcEn),     0);
        launch(3);
        @(negedge clk);
        check("mr_ProgIdx1", 32'(bus.ProgIdx),    1);
        check("mr_LoadAdr",  32'(bus.PcLoadAddr), 0);
        check("mr_PcLoad",   32'(bus.PcLoad),     1);

        // Fully random traffic including sporadic resets.
        repeat (3000) begin
            rst_n = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 3) == 0) bus.Start = ~bus.Start;
            bus.HaltInstr = ($urandom_range(0, 29) == 0);
            rand_exec();
            step();
        end

        // Long program to reach counter saturation.
        rst_n = 1'b0; bus.Start = 1'b0; clear_exec();
        step(); rst_n = 1'b1;
        launch(2); step();
        repeat (65540) step();
        @(negedge clk);
        check("sat_Cnt", 32'(bus.CycleCnt), 65535);
        bus.HaltInstr = 1'b1; step(); clear_exec();
        @(negedge clk);
        check("sat_Done",    32'(bus.Done),     1);
        check("sat_CntHeld", 32'(bus.CycleCnt), 65535);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Run controller that sequences the program counter across the three benchmark programs.
- Handshakes with the test bench on Start and Done.
- Issues PC load/enable controls: program-base jumps on Start, and conditional relative branches (base + Target) during execution.
- Stops fetching on a halt instruction and reports per-program cycle counts.
- Sits between the test bench, the instruction decoder/ALU and the PC register.

Parameters:
- A, 10, instruction-memory address width (PC width).
- NPROG, 3, number of programs in the series.
- CW, 16, cycle-counter width.

Ports:
- Clk  in  1  system clock; all state changes on posedge.
- Reset_n  in  1  synchronous reset, active-low.
- Start  in  1  test-bench request; a full high-then-low pulse launches the next program.
- HaltInstr  in  1  decoder: current instruction is halt.
- BranchRelEn  in  1  decoder: current instruction is a conditional branch.
- ALU_flag  in  1  ALU: branch condition met.
- Target  in  8  branch offset from program base, unsigned.
- PcEn  out  1  PC increments on this edge.
- PcLoad  out  1  PC loads PcLoadAddr on this edge; has priority over PcEn.
- PcLoadAddr  out  A  address to load.
- ProgIdx  out  2  current program number, 1..NPROG; 0 before the first Start.
- Done  out  1  current program halted; handshake to the test bench.
- AllDone  out  1  program NPROG halted; end of simulation.
- CycleCnt  out  CW  cycles spent in RUN for the current program.

Behaviour:
- States: IDLE, ARMED, RUN, HALTED, FINISHED.
- start_r registers Start. RiseEdge = Start & ~start_r. FallEdge = ~Start & start_r.
- Reset (Reset_n=0 at posedge) gives:
  - state=IDLE, start_r=0, ProgIdx=0, Done=0, AllDone=0, CycleCnt=0.
  - Combinational outputs PcEn=0, PcLoad=0, PcLoadAddr=0.
  - Reset mid-RUN aborts the program; no Done pulse is produced.
- IDLE or HALTED, on RiseEdge:
  - ProgIdx <= ProgIdx+1; Done <= 0; next state ARMED.
  - PC is frozen (PcEn=0).
- ARMED, on FallEdge:
  - PcLoad=1 combinationally, PcLoadAddr=BASE[ProgIdx].
  - state <= RUN; CycleCnt <= 0.
  - A further RiseEdge while ARMED is ignored.
- RUN:
  - PcEn=1 and CycleCnt increments each cycle, saturating at 2^CW-1.
  - If BranchRelEn & ALU_flag: PcLoad=1, PcLoadAddr = (BASE[ProgIdx] + zero-extended Target), truncated to A bits. Zero added latency: PC takes the target on the same edge.
  - If HaltInstr: PcEn=0, PcLoad=0, Done <= 1, state <= HALTED, or FINISHED if ProgIdx==NPROG (AllDone <= 1 as well). CycleCnt does not count the halt cycle.
  - Halt has priority over a branch in the same cycle.
  - Start edges during RUN are ignored.
- HALTED: Done held at 1, CycleCnt held, PC frozen.
- FINISHED:
  - Terminal. Done=1, AllDone=1, all Start activity ignored; only reset exits.
- ProgIdx never exceeds NPROG.
- Outputs Done, AllDone, ProgIdx and CycleCnt are registered. PcEn, PcLoad and PcLoadAddr are combinational from state and inputs. PcLoadAddr=0 whenever PcLoad=0.

Decomposition:
- Package prog_seq_pkg holds:
  - the state enum seq_state_t;
  - the NPROG default;
  - the base-address table BASE[1..3] = 0, 150, 500, as A-bit constants.
- One sub-module, edge_det (Clk, Reset_n, In -> Rise, Fall), instantiated for Start.

Test Plan:
- Reset, then Start held low for 10 cycles -> PcEn=0, PcLoad=0, ProgIdx=0, Done=0 throughout.
- Start high 3 cycles then low -> ProgIdx=1, and on the cycle after the fall PcLoad=1 with PcLoadAddr=0. Next cycle: RUN, PcEn=1, CycleCnt=1 after one cycle.
- Second program: launch program 2, then BranchRelEn=1, ALU_flag=1, Target=8'd37 -> PcLoad=1, PcLoadAddr=187. Repeat with ALU_flag=0 -> PcLoad=0, PcEn=1.
- HaltInstr=1 and BranchRelEn=1, ALU_flag=1 in the same cycle after 20 RUN cycles -> PcLoad=0, PcEn=0, Done=1 next cycle, CycleCnt=20 held. A Start pulse mid-RUN earlier in the sequence leaves ProgIdx unchanged.
- Third program: launch with PcLoadAddr=500, branch Target=255 -> PcLoadAddr=755. Halt -> Done=1, AllDone=1. A further Start pulse changes nothing.
- Reset_n=0 for one cycle mid-RUN of program 2 -> all outputs return to reset values at the next edge. Next Start yields ProgIdx=1, load address 0.
